// File: rtl/parking_gate_controller_if.sv
// Sensor, gate and status signals between the parking gate controller and its environment.
// The master drives the sensor levels. The slave is the controller, which returns gate state and pulses.
interface parking_gate_controller_if;
  logic       entry_req;
  logic       exit_req;
  logic       door_open;
  logic       full_parking;
  logic       entry_grant;
  logic       exit_grant;
  logic       entry_reject;
  logic [3:0] occupancy;

  modport master (
    output entry_req,
    output exit_req,
    input  door_open,
    input  full_parking,
    input  entry_grant,
    input  exit_grant,
    input  entry_reject,
    input  occupancy
  );

  modport slave (
    input  entry_req,
    input  exit_req,
    output door_open,
    output full_parking,
    output entry_grant,
    output exit_grant,
    output entry_reject,
    output occupancy
  );
endinterface

// File: rtl/parking_gate_controller.sv
// Single-gate parking controller: edge-detected entry/exit requests, IDLE/OPEN/CLOSING timing,
// fair arbitration and a saturating occupancy count. All outputs are registered.
module parking_gate_controller #(
  parameter int CAPACITY     = 8,
  parameter int OPEN_CYCLES  = 400_000_000,
  parameter int CLOSE_CYCLES = 40_000_000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  parking_gate_controller_if.slave  gate
);

  localparam logic [3:0]  CAP        = 4'(CAPACITY);
  localparam logic [31:0] OPEN_LAST  = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0] CLOSE_LAST = 32'(CLOSE_CYCLES - 1);
  localparam logic        DIR_ENTRY  = 1'b0;
  localparam logic        DIR_EXIT   = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    CLOSING = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] timer, timer_nx;
  logic        hist_vld;
  logic        entry_prev, exit_prev;
  logic        entry_rise, exit_rise;
  logic        entry_pend, exit_pend;
  logic        entry_pend_nx, exit_pend_nx;
  logic        entry_clr, exit_clr;
  logic        serve_entry, serve_exit;
  logic        last_dir, last_dir_nx;
  logic        is_full, is_empty;
  logic [3:0]  occ, occ_nx;
  logic        door_q, door_nx;
  logic        full_q, full_nx;
  logic        egrant_q, egrant_nx;
  logic        xgrant_q, xgrant_nx;
  logic        reject_q, reject_nx;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= CAP) ? CAP : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  // The first clock after reset only loads the edge history. This stops a level that is held
  // high through reset release from being taken as a fresh request.
  assign entry_rise = hist_vld & gate.entry_req & ~entry_prev;
  assign exit_rise  = hist_vld & gate.exit_req  & ~exit_prev;

  assign is_full  = (occ == CAP);
  assign is_empty = (occ == 4'd0);

  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    entry_clr   = 1'b0;
    exit_clr    = 1'b0;
    serve_entry = 1'b0;
    serve_exit  = 1'b0;
    last_dir_nx = last_dir;
    occ_nx      = occ;
    door_nx     = door_q;
    egrant_nx   = 1'b0;
    xgrant_nx   = 1'b0;
    reject_nx   = 1'b0;

    case (state)
      IDLE: begin
        if (exit_pend && is_empty) begin
          exit_clr = 1'b1;
        end
        // When both are pending, a full lot forces exit; otherwise alternate against last_dir
        if (entry_pend && exit_pend && !is_empty) begin
          if (is_full || last_dir == DIR_ENTRY) serve_exit  = 1'b1;
          else                                  serve_entry = 1'b1;
        end else if (entry_pend) begin
          if (is_full) begin
            entry_clr = 1'b1;
            reject_nx = 1'b1;
          end else begin
            serve_entry = 1'b1;
          end
        end else if (exit_pend && !is_empty) begin
          serve_exit = 1'b1;
        end

        if (serve_entry) begin
          entry_clr   = 1'b1;
          egrant_nx   = 1'b1;
          occ_nx      = sat_inc(occ);
          last_dir_nx = DIR_ENTRY;
        end
        if (serve_exit) begin
          exit_clr    = 1'b1;
          xgrant_nx   = 1'b1;
          occ_nx      = sat_dec(occ);
          last_dir_nx = DIR_EXIT;
        end
        if (serve_entry || serve_exit) begin
          state_nx = OPEN;
          timer_nx = 32'd0;
          door_nx  = 1'b1;
        end
      end

      OPEN: begin
        if (timer == OPEN_LAST) begin
          state_nx = CLOSING;
          timer_nx = 32'd0;
          door_nx  = 1'b0;
        end else begin
          timer_nx = timer + 32'd1;
        end
      end

      CLOSING: begin
        if (timer == CLOSE_LAST) begin
          state_nx = IDLE;
          timer_nx = 32'd0;
        end else begin
          timer_nx = timer + 32'd1;
        end
      end

      default: begin
        state_nx = IDLE;
        timer_nx = 32'd0;
        door_nx  = 1'b0;
      end
    endcase

    full_nx       = (occ_nx == CAP);
    entry_pend_nx = (entry_pend & ~entry_clr) | entry_rise;
    exit_pend_nx  = (exit_pend  & ~exit_clr)  | exit_rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= 32'd0;
      hist_vld   <= 1'b0;
      entry_prev <= 1'b0;
      exit_prev  <= 1'b0;
      entry_pend <= 1'b0;
      exit_pend  <= 1'b0;
      last_dir   <= DIR_EXIT;
      occ        <= 4'd0;
      door_q     <= 1'b0;
      full_q     <= 1'b0;
      egrant_q   <= 1'b0;
      xgrant_q   <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      hist_vld   <= 1'b1;
      entry_prev <= gate.entry_req;
      exit_prev  <= gate.exit_req;
      entry_pend <= entry_pend_nx;
      exit_pend  <= exit_pend_nx;
      last_dir   <= last_dir_nx;
      occ        <= occ_nx;
      door_q     <= door_nx;
      full_q     <= full_nx;
      egrant_q   <= egrant_nx;
      xgrant_q   <= xgrant_nx;
      reject_q   <= reject_nx;
    end
  end

  assign gate.door_open    = door_q;
  assign gate.full_parking = full_q;
  assign gate.entry_grant  = egrant_q;
  assign gate.exit_grant   = xgrant_q;
  assign gate.entry_reject = reject_q;
  assign gate.occupancy    = occ;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller with CAPACITY=2, OPEN_CYCLES=4, CLOSE_CYCLES=2.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_parking_gate_controller;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  parking_gate_controller_if gif ();

  parking_gate_controller #(
    .CAPACITY     (2),
    .OPEN_CYCLES  (4),
    .CLOSE_CYCLES (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .gate    (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs the 3 remaining OPEN cycles after a grant and the 3 cycles that end back in IDLE.
  task automatic finish_gate();
    repeat (3) begin
      step();
      chk("door_open_hold", {31'd0, gif.door_open}, 32'd1);
    end
    repeat (3) begin
      step();
      chk("door_closed", {31'd0, gif.door_open}, 32'd0);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset_n      = 1'b0;
    gif.entry_req = 1'b0;
    gif.exit_req  = 1'b0;

    repeat (2) step();
    chk("rst_door",   {31'd0, gif.door_open},    32'd0);
    chk("rst_full",   {31'd0, gif.full_parking}, 32'd0);
    chk("rst_egrant", {31'd0, gif.entry_grant},  32'd0);
    chk("rst_xgrant", {31'd0, gif.exit_grant},   32'd0);
    chk("rst_reject", {31'd0, gif.entry_reject}, 32'd0);
    chk("rst_occ",    {28'd0, gif.occupancy},    32'd0);
    reset_n = 1'b1;
    repeat (2) step();

    // Exit at empty lot is dropped
    gif.exit_req = 1'b1;
    step();
    gif.exit_req = 1'b0;
    step();
    chk("empty_exit_grant", {31'd0, gif.exit_grant}, 32'd0);
    chk("empty_exit_door",  {31'd0, gif.door_open},  32'd0);
    chk("empty_exit_occ",   {28'd0, gif.occupancy},  32'd0);
    step();
    chk("empty_exit_door2", {31'd0, gif.door_open},  32'd0);
    chk("empty_exit_occ2",  {28'd0, gif.occupancy},  32'd0);

    // First entry: grant, 4 open cycles, then CLOSING
    gif.entry_req = 1'b1;
    step();
    gif.entry_req = 1'b0;
    chk("e1_pre_grant", {31'd0, gif.entry_grant}, 32'd0);
    step();
    chk("e1_grant", {31'd0, gif.entry_grant},  32'd1);
    chk("e1_door",  {31'd0, gif.door_open},    32'd1);
    chk("e1_occ",   {28'd0, gif.occupancy},    32'd1);
    chk("e1_full",  {31'd0, gif.full_parking}, 32'd0);
    repeat (3) begin
      step();
      chk("e1_door_hold",  {31'd0, gif.door_open},   32'd1);
      chk("e1_grant_once", {31'd0, gif.entry_grant}, 32'd0);
    end
    step();
    chk("e1_door_close", {31'd0, gif.door_open}, 32'd0);

    // Second entry requested during CLOSING, served once IDLE is reached
    gif.entry_req = 1'b1;
    step();
    gif.entry_req = 1'b0;
    chk("e2_closing_door", {31'd0, gif.door_open}, 32'd0);
    step();
    chk("e2_not_before_idle", {31'd0, gif.entry_grant}, 32'd0);
    step();
    chk("e2_grant", {31'd0, gif.entry_grant},  32'd1);
    chk("e2_occ",   {28'd0, gif.occupancy},    32'd2);
    chk("e2_full",  {31'd0, gif.full_parking}, 32'd1);
    chk("e2_door",  {31'd0, gif.door_open},    32'd1);

    // Third entry raised during OPEN; rejected once the lot is seen full from IDLE
    step();
    gif.entry_req = 1'b1;
    chk("e2_door_hold1", {31'd0, gif.door_open}, 32'd1);
    step();
    gif.entry_req = 1'b0;
    chk("e2_door_hold2", {31'd0, gif.door_open}, 32'd1);
    step();
    chk("e2_door_hold3", {31'd0, gif.door_open}, 32'd1);
    repeat (3) begin
      step();
      chk("e2_closed", {31'd0, gif.door_open}, 32'd0);
    end
    step();
    chk("e3_reject", {31'd0, gif.entry_reject}, 32'd1);
    chk("e3_grant",  {31'd0, gif.entry_grant},  32'd0);
    chk("e3_door",   {31'd0, gif.door_open},    32'd0);
    chk("e3_occ",    {28'd0, gif.occupancy},    32'd2);
    step();
    chk("e3_reject_once", {31'd0, gif.entry_reject}, 32'd0);
    chk("e3_door2",       {31'd0, gif.door_open},    32'd0);
    chk("e3_full",        {31'd0, gif.full_parking}, 32'd1);

    // Full lot with both pending: exit first, then the waiting entry
    gif.entry_req = 1'b1;
    gif.exit_req  = 1'b1;
    step();
    gif.entry_req = 1'b0;
    gif.exit_req  = 1'b0;
    step();
    chk("full_tie_xgrant", {31'd0, gif.exit_grant},   32'd1);
    chk("full_tie_egrant", {31'd0, gif.entry_grant},  32'd0);
    chk("full_tie_occ",    {28'd0, gif.occupancy},    32'd1);
    chk("full_tie_full",   {31'd0, gif.full_parking}, 32'd0);
    repeat (3) step();
    step();
    chk("full_tie_closing", {31'd0, gif.door_open}, 32'd0);
    step();
    step();
    chk("full_tie_entry_wait", {31'd0, gif.entry_grant}, 32'd0);
    step();
    chk("full_tie_egrant2", {31'd0, gif.entry_grant},  32'd1);
    chk("full_tie_reject",  {31'd0, gif.entry_reject}, 32'd0);
    chk("full_tie_occ2",    {28'd0, gif.occupancy},    32'd2);
    chk("full_tie_full2",   {31'd0, gif.full_parking}, 32'd1);
    finish_gate();

    // Lone exit so that the last served direction is exit
    gif.exit_req = 1'b1;
    step();
    gif.exit_req = 1'b0;
    step();
    chk("x1_grant", {31'd0, gif.exit_grant}, 32'd1);
    chk("x1_occ",   {28'd0, gif.occupancy},  32'd1);
    finish_gate();

    // Simultaneous rise at occupancy 1: entry first, exit after CLOSING
    gif.entry_req = 1'b1;
    gif.exit_req  = 1'b1;
    step();
    gif.entry_req = 1'b0;
    gif.exit_req  = 1'b0;
    step();
    chk("tie_egrant", {31'd0, gif.entry_grant},  32'd1);
    chk("tie_xgrant", {31'd0, gif.exit_grant},   32'd0);
    chk("tie_occ",    {28'd0, gif.occupancy},    32'd2);
    chk("tie_full",   {31'd0, gif.full_parking}, 32'd1);
    repeat (3) step();
    step();
    chk("tie_closing", {31'd0, gif.door_open}, 32'd0);
    step();
    step();
    chk("tie_exit_wait", {31'd0, gif.exit_grant}, 32'd0);
    step();
    chk("tie_xgrant2", {31'd0, gif.exit_grant},   32'd1);
    chk("tie_occ2",    {28'd0, gif.occupancy},    32'd1);
    chk("tie_full2",   {31'd0, gif.full_parking}, 32'd0);
    finish_gate();

    // Reset in OPEN cycle 2 while entry_req stays high through release
    gif.entry_req = 1'b1;
    step();
    step();
    chk("rs_grant", {31'd0, gif.entry_grant}, 32'd1);
    chk("rs_occ",   {28'd0, gif.occupancy},   32'd2);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_async_door", {31'd0, gif.door_open},    32'd0);
    chk("rs_async_occ",  {28'd0, gif.occupancy},    32'd0);
    chk("rs_async_full", {31'd0, gif.full_parking}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    repeat (8) begin
      step();
      chk("rs_held_no_grant", {31'd0, gif.entry_grant}, 32'd0);
      chk("rs_held_door",     {31'd0, gif.door_open},   32'd0);
    end
    gif.entry_req = 1'b0;
    step();
    gif.entry_req = 1'b1;
    step();
    gif.entry_req = 1'b0;
    step();
    chk("rs_new_edge_grant", {31'd0, gif.entry_grant}, 32'd1);
    chk("rs_new_edge_occ",   {28'd0, gif.occupancy},   32'd1);
    finish_gate();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
